// File: rtl/arduino_link_tx_if.sv
// Parallel link between the vision block and the Arduino GPIO header.
// The master drives the request strobe, control code, channel index and
// chunk payload. The slave (the Arduino) answers with an asynchronous ack.
interface arduino_link_if #(
  parameter int CH_W  = 2,
  parameter int VAL_W = 5
);
  logic             link_req;
  logic             link_ack;
  logic [1:0]       link_ctrl;
  logic [CH_W-1:0]  link_ch;
  logic [VAL_W-1:0] link_val;

  modport master (
    output link_req,
    output link_ctrl,
    output link_ch,
    output link_val,
    input  link_ack
  );

  modport slave (
    input  link_req,
    input  link_ctrl,
    input  link_ch,
    input  link_val,
    output link_ack
  );
endinterface

// File: rtl/arduino_link_tx.sv
// arduino_link_tx: snapshots one frame of per-channel detection results and
// sends it to the Arduino as VAL_W-bit chunks. Chunks go most-significant
// first over a 4-phase req/ack handshake, and the frame ends with an
// end-of-frame transfer.
// Every handshake phase is bounded by TIMEOUT cycles. When a phase runs
// out, the frame is dropped and the sticky err_timeout flag is raised.
// Optional build macro ARDUINO_LINK_CSUM_EN: when it is defined, the EOF
// payload is the XOR of every chunk payload sent in the frame. Otherwise
// the EOF payload is zero.
module arduino_link_tx #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 10,
  parameter int VAL_W   = 5,
  parameter int TIMEOUT = 50000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_mask,
  arduino_link_if.master           link,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int NCHUNK = (DATA_W + VAL_W - 1) / VAL_W;
  localparam int CK_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int PAD_W  = NCHUNK * VAL_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REQ, S_REL, S_EOF_REQ, S_EOF_REL
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_ack_meta;
  logic                    r_ack_s;
  logic [NUM_CH*DATA_W-1:0] r_snap;
  logic [NUM_CH-1:0]       r_pending;
  logic [CH_W-1:0]         r_ch;
  logic [CK_W-1:0]         r_chunk;
  logic                    r_first;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_load_ch;
  logic                    w_next_chunk;
  logic                    w_ch_done;
  logic                    w_xfer;
  logic                    w_timeout;
  logic                    w_phase;
  logic                    w_found;
  logic [CH_W-1:0]         w_sel;
  logic [DATA_W-1:0]       w_chan;
  logic [PAD_W-1:0]        w_padded;
  logic [VAL_W-1:0]        w_chunk_val;
  logic [VAL_W-1:0]        w_eof_val;
  logic                    w_req;
  logic [1:0]              w_ctrl;
  logic [CH_W-1:0]         w_ch;
  logic [VAL_W-1:0]        w_val;

  // Bring the asynchronous Arduino ack into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= link.link_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Pick the lowest-index channel that still has to be sent
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(i);
      end
    end
  end

  // Slice the current chunk out of the zero-padded channel result
  always_comb begin
    w_chan = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == CH_W'(i)) w_chan = r_snap[i*DATA_W +: DATA_W];
    end
    w_padded    = PAD_W'(w_chan);
    w_chunk_val = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_chunk == CK_W'(k)) w_chunk_val = w_padded[k*VAL_W +: VAL_W];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic, handshake strobes and link outputs
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_load_ch    = 1'b0;
    w_next_chunk = 1'b0;
    w_ch_done    = 1'b0;
    w_xfer       = 1'b0;
    w_timeout    = 1'b0;
    w_req        = 1'b0;
    w_ctrl       = 2'b00;
    w_ch         = '0;
    w_val        = '0;
    w_in_ready   = (r_state == S_IDLE) && !reset;
    w_phase      = (r_state == S_REQ) || (r_state == S_REL) ||
                   (r_state == S_EOF_REQ) || (r_state == S_EOF_REL);
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_in_ready) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_found) begin
          w_load_ch = 1'b1;
          w_next    = S_REQ;
        end else begin
          w_next    = S_EOF_REQ;
        end
      end
      S_REQ: begin
        w_req  = 1'b1;
        w_ctrl = r_first ? 2'b01 : 2'b10;
        w_ch   = r_ch;
        w_val  = w_chunk_val;
        if (r_ack_s) begin
          w_xfer = 1'b1;
          w_next = S_REL;
        end
      end
      S_REL: begin
        w_ctrl = r_first ? 2'b01 : 2'b10;
        w_ch   = r_ch;
        w_val  = w_chunk_val;
        if (!r_ack_s) begin
          if (r_chunk != '0) begin
            w_next_chunk = 1'b1;
            w_next       = S_REQ;
          end else begin
            w_ch_done    = 1'b1;
            w_next       = S_LOAD;
          end
        end
      end
      S_EOF_REQ: begin
        w_req  = 1'b1;
        w_ctrl = 2'b11;
        w_val  = w_eof_val;
        if (r_ack_s) w_next = S_EOF_REL;
      end
      S_EOF_REL: begin
        w_ctrl = 2'b11;
        w_val  = w_eof_val;
        if (!r_ack_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A phase that sits still for TIMEOUT cycles abandons the whole frame
    if (w_phase && (w_next == r_state) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
      w_timeout    = 1'b1;
      w_next       = S_IDLE;
      w_xfer       = 1'b0;
      w_next_chunk = 1'b0;
      w_ch_done    = 1'b0;
    end
  end

  // Phase counter: restarts on every state entry, runs during handshake phases
  always_ff @(posedge clk) begin
    if (reset)                  r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (w_phase)           r_cnt <= r_cnt + CNT_W'(1);
  end

  // Frame progress: pending channels, current channel and chunk position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_ch      <= '0;
      r_chunk   <= '0;
      r_first   <= 1'b0;
    end else begin
      if (w_accept) r_pending <= in_mask;
      if (w_load_ch) begin
        r_ch    <= w_sel;
        r_chunk <= CK_W'(NCHUNK - 1);
        r_first <= 1'b1;
      end
      if (w_next_chunk) begin
        r_chunk <= r_chunk - CK_W'(1);
        r_first <= 1'b0;
      end
      if (w_ch_done) r_pending[r_ch] <= 1'b0;
    end
  end

  // Frame snapshot; contents only matter after an accept
  always_ff @(posedge clk) begin
    if (w_accept) r_snap <= in_data;
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)          r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

`ifdef ARDUINO_LINK_CSUM_EN
  logic [VAL_W-1:0] r_csum;

  // Running XOR of every chunk payload the Arduino has taken this frame
  always_ff @(posedge clk) begin
    if (w_accept)    r_csum <= '0;
    else if (w_xfer) r_csum <= r_csum ^ w_chunk_val;
  end

  assign w_eof_val = r_csum;
`else
  assign w_eof_val = '0;
`endif

  assign in_ready       = w_in_ready;
  assign busy           = (r_state != S_IDLE);
  assign err_timeout    = r_err;
  assign link.link_req  = w_req;
  assign link.link_ctrl = w_ctrl;
  assign link.link_ch   = w_ch;
  assign link.link_val  = w_val;

endmodule
